kernel_bank: RTL and testbench

Runtime-selectable, host-writable bank of convolution kernels that replaces the fixed compile-time kernel selector. It sits between the control/host interface and the convolution datapath. It holds NUM_KERNELS coefficient sets of KSIZE x KSIZE taps plus a right-shift, and presents one active set to the datapath. Kernel switches take effect only on a frame boundary, so a frame is never convolved with mixed coefficients.

---
 rtl/kernel_pkg.sv | 58 +++++
 rtl/kernel_slot_mem.sv | 66 ++++++
 rtl/kernel_bank.sv | 151 +++++++++++++++
 tb/tb_kernel_bank.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kernel_pkg.sv
// Shared definitions for the convolution kernel bank.
//   kernel_id_e     : ids of the standard kernels loaded at reset
//   state_e         : select FSM states
//   default_kernel  : reset taps of a slot, centred in a KSIZE x KSIZE grid
//   default_shift   : reset normalisation shift of a slot
package kernel_pkg;

  typedef enum logic [2:0] {
    K_IDENTITY = 3'd0,
    K_GAUSSIAN = 3'd1,
    K_SHARPEN  = 3'd2,
    K_RIDGE    = 3'd3,
    K_SOBEL_X  = 3'd4,
    K_SOBEL_Y  = 3'd5
  } kernel_id_e;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_PENDING = 1'b1
  } state_e;

  // Default taps are carried at a fixed width large enough for 5x5 grids
  // and the value range -2..8; callers resize them to their coefficient width.
  localparam int MAX_TAPS = 25;
  localparam int TAP_W    = 8;

  typedef logic [TAP_W-1:0]                tap_t;
  typedef logic [MAX_TAPS-1:0][TAP_W-1:0]  taps_t;

  // Tap i sits at index r*ksize+c. The 3x3 pattern is placed in the centre
  // of the grid so a 5x5 kernel gets a zero border.
  function automatic taps_t default_kernel(input int id, input int ksize);
    int    k3 [9];
    int    off;
    taps_t t;
    case (id)
      int'(K_GAUSSIAN): k3 = '{ 1,  2,  1,  2,  4,  2,  1,  2,  1};
      int'(K_SHARPEN):  k3 = '{ 0, -1,  0, -1,  5, -1,  0, -1,  0};
      int'(K_RIDGE):    k3 = '{-1, -1, -1, -1,  8, -1, -1, -1, -1};
      int'(K_SOBEL_X):  k3 = '{ 1,  0, -1,  2,  0, -2,  1,  0, -1};
      int'(K_SOBEL_Y):  k3 = '{-1, -2, -1,  0,  0,  0,  1,  2,  1};
      default:          k3 = '{ 0,  0,  0,  0,  1,  0,  0,  0,  0};
    endcase
    t   = '0;
    off = (ksize - 3) / 2;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        t[(r + off) * ksize + c + off] = tap_t'(k3[r * 3 + c]);
      end
    end
    return t;
  endfunction

  function automatic int default_shift(input int id);
    return (id == int'(K_GAUSSIAN)) ? 4 : 0;
  endfunction

endpackage

// File: rtl/kernel_slot_mem.sv
// Register-array storage for all kernel slots.
//   clk_in, rst_n_in : clock, synchronous active-low reset (loads defaults)
//   wr_en_i          : write strobe, already qualified as in range
//   wr_slot_i        : slot written
//   wr_idx_i         : tap index, or KSIZE*KSIZE for the shift field
//   wr_data_i        : tap value; low SHIFT_WIDTH bits for the shift
//   rd_slot_i        : slot presented on the read port
//   rd_taps_o        : full tap set of rd_slot_i (combinational), tap 0 at LSBs
//   rd_shift_o       : shift of rd_slot_i (combinational)
module kernel_slot_mem
  import kernel_pkg::*;
#(
  parameter  int NUM_KERNELS = 8,
  parameter  int KSIZE       = 3,
  parameter  int COEFF_WIDTH = 8,
  parameter  int SHIFT_WIDTH = 4,
  localparam int NTAPS       = KSIZE * KSIZE,
  localparam int ID_W        = $clog2(NUM_KERNELS),
  localparam int IDX_W       = $clog2(NTAPS + 1)
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic                         wr_en_i,
  input  logic [ID_W-1:0]              wr_slot_i,
  input  logic [IDX_W-1:0]             wr_idx_i,
  input  logic [COEFF_WIDTH-1:0]       wr_data_i,
  input  logic [ID_W-1:0]              rd_slot_i,
  output logic [NTAPS*COEFF_WIDTH-1:0] rd_taps_o,
  output logic [SHIFT_WIDTH-1:0]       rd_shift_o
);

  localparam logic [IDX_W-1:0] SHIFT_IDX = IDX_W'(NTAPS);

  logic [NTAPS-1:0][COEFF_WIDTH-1:0] taps_q  [NUM_KERNELS];
  logic [SHIFT_WIDTH-1:0]            shift_q [NUM_KERNELS];

  // Default taps resized to the coefficient width with sign extension.
  function automatic logic [NTAPS-1:0][COEFF_WIDTH-1:0] default_taps(input int id);
    taps_t                             t;
    logic [NTAPS-1:0][COEFF_WIDTH-1:0] r;
    t = default_kernel(id, KSIZE);
    for (int i = 0; i < NTAPS; i++) begin
      r[i] = COEFF_WIDTH'($signed(t[i]));
    end
    return r;
  endfunction

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      for (int s = 0; s < NUM_KERNELS; s++) begin
        taps_q[s]  <= default_taps(s);
        shift_q[s] <= SHIFT_WIDTH'(default_shift(s));
      end
    end else if (wr_en_i) begin
      if (wr_idx_i == SHIFT_IDX) begin
        shift_q[wr_slot_i] <= wr_data_i[SHIFT_WIDTH-1:0];
      end else begin
        taps_q[wr_slot_i][wr_idx_i] <= wr_data_i;
      end
    end
  end

  assign rd_taps_o  = taps_q[rd_slot_i];
  assign rd_shift_o = shift_q[rd_slot_i];

endmodule

// File: rtl/kernel_bank.sv
// Host-writable bank of convolution kernels with frame-aligned switching.
//   clk_in, rst_n_in : clock, synchronous active-low reset
//   frame_start_in   : pulse at the first pixel of a frame; swap point
//   sel_valid_in     : select request strobe, sel_id_in = requested slot
//   wr_valid_in      : coefficient write strobe
//   wr_slot_in       : slot written
//   wr_idx_in        : tap index r*KSIZE+c, KSIZE*KSIZE = shift field
//   wr_data_in       : tap value / shift in the low bits
//   coeffs_out       : active taps, tap 0 at the LSBs
//   shift_out        : active shift
//   active_id_out    : slot that was last copied to the outputs
//   pending_out      : a select is waiting for the next frame start
//   err_out          : one-cycle pulse on an out-of-range select or write
module kernel_bank
  import kernel_pkg::*;
#(
  parameter  int NUM_KERNELS = 8,
  parameter  int KSIZE       = 3,
  parameter  int COEFF_WIDTH = 8,
  parameter  int SHIFT_WIDTH = 4,
  localparam int NTAPS       = KSIZE * KSIZE,
  localparam int ID_W        = $clog2(NUM_KERNELS),
  localparam int IDX_W       = $clog2(NTAPS + 1)
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic                         frame_start_in,
  input  logic                         sel_valid_in,
  input  logic [ID_W-1:0]              sel_id_in,
  input  logic                         wr_valid_in,
  input  logic [ID_W-1:0]              wr_slot_in,
  input  logic [IDX_W-1:0]             wr_idx_in,
  input  logic [COEFF_WIDTH-1:0]       wr_data_in,
  output logic [NTAPS*COEFF_WIDTH-1:0] coeffs_out,
  output logic [SHIFT_WIDTH-1:0]       shift_out,
  output logic [ID_W-1:0]              active_id_out,
  output logic                         pending_out,
  output logic                         err_out
);

  // Range checks are done one bit wider so that a power-of-two bank
  // (where no id can be out of range) still compares cleanly.
  localparam logic [ID_W:0]    NK_EXT    = (ID_W + 1)'(NUM_KERNELS);
  localparam logic [IDX_W-1:0] SHIFT_IDX = IDX_W'(NTAPS);

  function automatic logic [NTAPS*COEFF_WIDTH-1:0] identity_taps();
    logic [NTAPS*COEFF_WIDTH-1:0] r;
    r = '0;
    r[(NTAPS / 2) * COEFF_WIDTH +: COEFF_WIDTH] = COEFF_WIDTH'(1);
    return r;
  endfunction

  state_e                       state_q, state_d;
  logic [ID_W-1:0]              pend_id_q, pend_id_d;
  logic [ID_W-1:0]              active_id_q;
  logic [NTAPS*COEFF_WIDTH-1:0] coeffs_q;
  logic [SHIFT_WIDTH-1:0]       shift_q;
  logic                         err_q, err_d;

  logic                         sel_ok, sel_bad, wr_ok, wr_bad;
  logic [ID_W-1:0]              swap_id;
  logic [NTAPS*COEFF_WIDTH-1:0] rd_taps;
  logic [SHIFT_WIDTH-1:0]       rd_shift;

  assign sel_bad = sel_valid_in && ({1'b0, sel_id_in} >= NK_EXT);
  assign sel_ok  = sel_valid_in && !sel_bad;
  assign wr_bad  = wr_valid_in &&
                   (({1'b0, wr_slot_in} >= NK_EXT) || (wr_idx_in > SHIFT_IDX));
  assign wr_ok   = wr_valid_in && !wr_bad;

  kernel_slot_mem #(
    .NUM_KERNELS (NUM_KERNELS),
    .KSIZE       (KSIZE),
    .COEFF_WIDTH (COEFF_WIDTH),
    .SHIFT_WIDTH (SHIFT_WIDTH)
  ) u_mem (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .wr_en_i    (wr_ok),
    .wr_slot_i  (wr_slot_in),
    .wr_idx_i   (wr_idx_in),
    .wr_data_i  (wr_data_in),
    .rd_slot_i  (swap_id),
    .rd_taps_o  (rd_taps),
    .rd_shift_o (rd_shift)
  );

  // State and active registers. The read port shows the pre-write slot
  // contents, so a write and swap of the same slot copies the old values.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q     <= S_IDLE;
      pend_id_q   <= '0;
      active_id_q <= '0;
      coeffs_q    <= identity_taps();
      shift_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_id_q <= pend_id_d;
      err_q     <= err_d;
      if (frame_start_in) begin
        active_id_q <= swap_id;
        coeffs_q    <= rd_taps;
        shift_q     <= rd_shift;
      end
    end
  end

  // Next state: a frame start always resolves to IDLE because any request,
  // including one arriving in the same cycle, is consumed by that swap.
  always_comb begin
    state_d   = state_q;
    pend_id_d = pend_id_q;
    if (sel_ok) begin
      pend_id_d = sel_id_in;
    end
    case (state_q)
      S_IDLE: begin
        if (!frame_start_in && sel_ok) begin
          state_d = S_PENDING;
        end
      end
      S_PENDING: begin
        if (frame_start_in) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Swap source: newest request first, then a latched request, otherwise
  // re-copy the active slot so host writes to it become visible.
  always_comb begin
    swap_id = active_id_q;
    if (sel_ok) begin
      swap_id = sel_id_in;
    end else if (state_q == S_PENDING) begin
      swap_id = pend_id_q;
    end
    err_d = sel_bad || wr_bad;
  end

  assign coeffs_out    = coeffs_q;
  assign shift_out     = shift_q;
  assign active_id_out = active_id_q;
  assign pending_out   = (state_q == S_PENDING);
  assign err_out       = err_q;

endmodule

// File: tb/tb_kernel_bank.sv
// Scoreboard bench for kernel_bank: a 3x3/8-slot instance (A) and a
// 5x5/6-slot instance (B) share clock and reset. Stimulus pushes expected
// output values tagged with the cycle they must appear in; a monitor on the
// falling edge pops and compares them.
module tb_kernel_bank;

  localparam int O_A_CO = 0, O_A_SH = 1, O_A_ID = 2, O_A_PE = 3, O_A_ER = 4;
  localparam int O_B_CO = 5, O_B_SH = 6, O_B_ID = 7, O_B_PE = 8, O_B_ER = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_fs, a_sel_v, a_wr_v;
  logic [2:0]  a_sel_id, a_wr_slot;
  logic [3:0]  a_wr_idx;
  logic [7:0]  a_wr_data;
  logic [71:0] a_coeffs;
  logic [3:0]  a_shift;
  logic [2:0]  a_id;
  logic        a_pend, a_err;

  logic         b_fs, b_sel_v, b_wr_v;
  logic [2:0]   b_sel_id, b_wr_slot;
  logic [4:0]   b_wr_idx;
  logic [7:0]   b_wr_data;
  logic [199:0] b_coeffs;
  logic [3:0]   b_shift;
  logic [2:0]   b_id;
  logic         b_pend, b_err;

  kernel_bank dut_a (
    .clk_in(clk), .rst_n_in(rst_n), .frame_start_in(a_fs),
    .sel_valid_in(a_sel_v), .sel_id_in(a_sel_id),
    .wr_valid_in(a_wr_v), .wr_slot_in(a_wr_slot), .wr_idx_in(a_wr_idx),
    .wr_data_in(a_wr_data), .coeffs_out(a_coeffs), .shift_out(a_shift),
    .active_id_out(a_id), .pending_out(a_pend), .err_out(a_err)
  );

  kernel_bank #(.NUM_KERNELS(6), .KSIZE(5)) dut_b (
    .clk_in(clk), .rst_n_in(rst_n), .frame_start_in(b_fs),
    .sel_valid_in(b_sel_v), .sel_id_in(b_sel_id),
    .wr_valid_in(b_wr_v), .wr_slot_in(b_wr_slot), .wr_idx_in(b_wr_idx),
    .wr_data_in(b_wr_data), .coeffs_out(b_coeffs), .shift_out(b_shift),
    .active_id_out(b_id), .pending_out(b_pend), .err_out(b_err)
  );

  typedef struct {
    int           cyc;
    int           which;
    string        name;
    logic [255:0] val;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [255:0] pk3(input int t[9]);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 9; i++) r[i*8 +: 8] = 8'(t[i]);
    return r;
  endfunction

  function automatic logic [255:0] pk5(input int t[25]);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 25; i++) r[i*8 +: 8] = 8'(t[i]);
    return r;
  endfunction

  function automatic logic [255:0] obs(input int w);
    case (w)
      O_A_CO:  return 256'(a_coeffs);
      O_A_SH:  return 256'(a_shift);
      O_A_ID:  return 256'(a_id);
      O_A_PE:  return 256'(a_pend);
      O_A_ER:  return 256'(a_err);
      O_B_CO:  return 256'(b_coeffs);
      O_B_SH:  return 256'(b_shift);
      O_B_ID:  return 256'(b_id);
      O_B_PE:  return 256'(b_pend);
      default: return 256'(b_err);
    endcase
  endfunction

  // Queue kept sorted by cycle so the monitor can pop from the front.
  task automatic expect_at(input int off, input int w, input string nm,
                           input logic [255:0] v);
    exp_t e;
    int   i;
    e.cyc = cyc + off; e.which = w; e.name = nm; e.val = v;
    i = 0;
    while (i < q.size() && q[i].cyc <= e.cyc) i++;
    q.insert(i, e);
  endtask

  task automatic expect_i(input int off, input int w, input string nm, input int v);
    expect_at(off, w, nm, 256'(unsigned'(v)));
  endtask

  exp_t         m_e;
  logic [255:0] m_got;
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      m_e   = q.pop_front();
      m_got = obs(m_e.which);
      n_tests++;
      if (m_e.cyc != cyc) begin
        n_fail++;
        $display("FAIL %s: expectation for cycle %0d checked late at %0d", m_e.name, m_e.cyc, cyc);
      end else if (m_got !== m_e.val) begin
        n_fail++;
        $display("FAIL %s @%0d: got %0h expected %0h", m_e.name, cyc, m_got, m_e.val);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    a_fs = 0; a_sel_v = 0; a_wr_v = 0;
    b_fs = 0; b_sel_v = 0; b_wr_v = 0;
  endtask

  task automatic a_write(input int slot, input int idx, input int data);
    a_wr_v = 1; a_wr_slot = 3'(slot); a_wr_idx = 4'(idx); a_wr_data = 8'(data);
    tick();
  endtask

  logic [255:0] ID3, GAUSS3, RIDGE3, SOBY3, ID5, GAUSS5, SOBX5;

  initial begin
    ID3    = pk3('{0, 0, 0, 0, 1, 0, 0, 0, 0});
    GAUSS3 = pk3('{1, 2, 1, 2, 4, 2, 1, 2, 1});
    RIDGE3 = pk3('{-1, -1, -1, -1, 8, -1, -1, -1, -1});
    SOBY3  = pk3('{-1, -2, -1, 0, 0, 0, 1, 2, 1});
    ID5    = pk5('{0,0,0,0,0, 0,0,0,0,0, 0,0,1,0,0, 0,0,0,0,0, 0,0,0,0,0});
    GAUSS5 = pk5('{0,0,0,0,0, 0,1,2,1,0, 0,2,4,2,0, 0,1,2,1,0, 0,0,0,0,0});
    SOBX5  = pk5('{0,0,0,0,0, 0,1,0,-1,0, 0,2,0,-2,0, 0,1,0,-1,0, 0,0,0,0,0});

    a_fs = 0; a_sel_v = 0; a_sel_id = 0; a_wr_v = 0; a_wr_slot = 0; a_wr_idx = 0; a_wr_data = 0;
    b_fs = 0; b_sel_v = 0; b_sel_id = 0; b_wr_v = 0; b_wr_slot = 0; b_wr_idx = 0; b_wr_data = 0;
    rst_n = 0;
    repeat (3) tick();
    rst_n = 1;

    // reset values
    expect_at(0, O_A_CO, "rst_a_coeffs", ID3);
    expect_i(0, O_A_SH, "rst_a_shift", 0);
    expect_i(0, O_A_ID, "rst_a_id", 0);
    expect_i(0, O_A_PE, "rst_a_pending", 0);
    expect_i(0, O_A_ER, "rst_a_err", 0);
    expect_at(0, O_B_CO, "rst_b_coeffs", ID5);
    expect_i(0, O_B_PE, "rst_b_pending", 0);

    // select Gaussian, swap on frame start
    a_sel_v = 1; a_sel_id = 1;
    expect_i(1, O_A_PE, "sel1_pending", 1);
    expect_i(1, O_A_ID, "sel1_id_before_swap", 0);
    expect_at(1, O_A_CO, "sel1_coeffs_before_swap", ID3);
    tick();
    expect_i(1, O_A_PE, "sel1_pending_held", 1);
    tick();
    a_fs = 1;
    expect_i(1, O_A_PE, "swap1_pending", 0);
    expect_i(1, O_A_SH, "swap1_shift", 4);
    expect_at(1, O_A_CO, "swap1_coeffs", GAUSS3);
    expect_i(1, O_A_ID, "swap1_id", 1);
    tick();
    expect_at(1, O_A_CO, "swap1_coeffs_hold", GAUSS3);
    tick();

    // program slot 6, then switch to it
    a_write(6, 4, -3);
    a_write(6, 9, 2);
    a_sel_v = 1; a_sel_id = 6;
    tick();
    a_fs = 1;
    expect_at(1, O_A_CO, "slot6_coeffs", pk3('{0, 0, 0, 0, -3, 0, 0, 0, 0}));
    expect_i(1, O_A_SH, "slot6_shift", 2);
    expect_i(1, O_A_ID, "slot6_id", 6);
    tick();

    // select and frame start in the same cycle
    a_sel_v = 1; a_sel_id = 1; a_fs = 1;
    expect_i(1, O_A_ID, "samecyc_id", 1);
    expect_at(1, O_A_CO, "samecyc_coeffs", GAUSS3);
    expect_i(1, O_A_PE, "samecyc_pending", 0);
    tick();

    // write to active slot is invisible until the next frame start
    expect_at(1, O_A_CO, "actwr_unchanged1", GAUSS3);
    expect_at(2, O_A_CO, "actwr_unchanged2", GAUSS3);
    a_write(1, 0, 7);
    tick();
    a_fs = 1;
    expect_at(1, O_A_CO, "actwr_applied", pk3('{7, 2, 1, 2, 4, 2, 1, 2, 1}));
    expect_i(1, O_A_ID, "actwr_id", 1);
    expect_i(1, O_A_SH, "actwr_shift", 4);
    tick();

    // last request wins
    a_sel_v = 1; a_sel_id = 2;
    tick();
    a_sel_v = 1; a_sel_id = 3;
    expect_i(1, O_A_PE, "lastwins_pending", 1);
    expect_i(1, O_A_ID, "lastwins_id_before", 1);
    tick();
    a_fs = 1;
    expect_i(1, O_A_ID, "lastwins_id", 3);
    expect_at(1, O_A_CO, "lastwins_ridge", RIDGE3);
    expect_i(1, O_A_SH, "lastwins_shift", 0);
    tick();

    // write and swap of the same slot in one cycle copies pre-write data
    a_sel_v = 1; a_sel_id = 5; a_fs = 1;
    expect_at(1, O_A_CO, "soby_coeffs", SOBY3);
    tick();
    a_wr_v = 1; a_wr_slot = 5; a_wr_idx = 0; a_wr_data = 8'd9; a_fs = 1;
    expect_at(1, O_A_CO, "wrswap_prewrite", SOBY3);
    tick();
    a_fs = 1;
    expect_at(1, O_A_CO, "wrswap_postwrite", pk3('{9, -2, -1, 0, 0, 0, 1, 2, 1}));
    tick();

    // out-of-range tap index
    a_wr_v = 1; a_wr_slot = 0; a_wr_idx = 4'd10; a_wr_data = 8'h55;
    expect_i(1, O_A_ER, "badidx_err", 1);
    expect_i(2, O_A_ER, "badidx_err_clear", 0);
    expect_i(1, O_A_PE, "badidx_pending", 0);
    tick();
    tick();
    a_fs = 1;
    expect_at(1, O_A_CO, "badidx_nochange", pk3('{9, -2, -1, 0, 0, 0, 1, 2, 1}));
    expect_i(1, O_A_ID, "badidx_id", 5);
    tick();

    // reset while pending
    a_sel_v = 1; a_sel_id = 2;
    expect_i(1, O_A_PE, "prerst_pending", 1);
    tick();
    rst_n = 0;
    expect_i(1, O_A_PE, "midrst_pending", 0);
    expect_at(1, O_A_CO, "midrst_coeffs", ID3);
    expect_i(1, O_A_ID, "midrst_id", 0);
    expect_i(1, O_A_SH, "midrst_shift", 0);
    tick();
    rst_n = 1;
    a_fs = 1;
    expect_at(1, O_A_CO, "midrst_no_swap", ID3);
    tick();
    a_sel_v = 1; a_sel_id = 1; a_fs = 1;
    expect_at(1, O_A_CO, "midrst_slot1_default", GAUSS3);
    tick();
    a_sel_v = 1; a_sel_id = 5; a_fs = 1;
    expect_at(1, O_A_CO, "midrst_slot5_default", SOBY3);
    tick();

    // 5x5 instance
    b_sel_v = 1; b_sel_id = 1; b_fs = 1;
    expect_at(1, O_B_CO, "b_gauss5", GAUSS5);
    expect_i(1, O_B_SH, "b_gauss5_shift", 4);
    expect_i(1, O_B_ID, "b_gauss5_id", 1);
    tick();
    b_sel_v = 1; b_sel_id = 4;
    expect_i(1, O_B_PE, "b_sel4_pending", 1);
    tick();
    b_fs = 1;
    expect_at(1, O_B_CO, "b_sobx5", SOBX5);
    expect_i(1, O_B_ID, "b_sobx5_id", 4);
    expect_i(1, O_B_SH, "b_sobx5_shift", 0);
    tick();

    b_sel_v = 1; b_sel_id = 7;
    expect_i(1, O_B_ER, "b_badsel_err", 1);
    expect_i(2, O_B_ER, "b_badsel_err_clear", 0);
    expect_i(1, O_B_PE, "b_badsel_pending", 0);
    tick();
    tick();
    b_wr_v = 1; b_wr_slot = 6; b_wr_idx = 0; b_wr_data = 8'd5;
    expect_i(1, O_B_ER, "b_badslot_err", 1);
    expect_i(2, O_B_ER, "b_badslot_err_clear", 0);
    tick();
    tick();
    b_wr_v = 1; b_wr_slot = 4; b_wr_idx = 5'd26; b_wr_data = 8'd5;
    expect_i(1, O_B_ER, "b_badidx_err", 1);
    tick();
    b_sel_v = 1; b_sel_id = 7; b_wr_v = 1; b_wr_slot = 7; b_wr_idx = 0; b_wr_data = 8'd3;
    expect_i(1, O_B_ER, "b_dualerr_err", 1);
    expect_i(2, O_B_ER, "b_dualerr_single", 0);
    expect_i(1, O_B_PE, "b_dualerr_pending", 0);
    tick();
    tick();
    b_fs = 1;
    expect_at(1, O_B_CO, "b_err_nochange", SOBX5);
    expect_i(1, O_B_ID, "b_err_nochange_id", 4);
    tick();
    b_wr_v = 1; b_wr_slot = 4; b_wr_idx = 5'd25; b_wr_data = 8'd3;
    tick();
    b_fs = 1;
    expect_i(1, O_B_SH, "b_shift_write", 3);
    expect_at(1, O_B_CO, "b_shift_write_coeffs", SOBX5);
    tick();

    repeat (3) tick();
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
